// File: rtl/membus_pkg.sv
// Shared types for the device-bus arbiter: FSM encodings, master IDs, default widths.
// Pure declarations; no latency and no flow control of its own.
package membus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/membus_arbiter_if.sv
// One master's single-beat request/ack channel into the arbiter.
// The master holds req/we/addr/wdata until its one-cycle ack; there is no other backpressure.
interface membus_arbiter_if #(
    parameter int ADDR_W = membus_pkg::ADDR_W_DEF,
    parameter int DATA_W = membus_pkg::DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/membus_pick.sv
// Winner selection for two requesters plus the last-grant and starvation history.
// Combinational pick (0 cycles); only fires while the arbiter is idle.
module membus_pick
    import membus_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_LIM = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       arb_en_i,
    output logic       winner_o,
    output logic       fire_o
);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic       last_gnt_q, last_gnt_d;
    logic [3:0] starve_q, starve_d;
    logic       contested;

    always_comb begin
        contested  = req_i[0] & req_i[1];
        fire_o     = arb_en_i & (|req_i);
        winner_o   = M_CPU;
        last_gnt_d = last_gnt_q;
        starve_d   = starve_q;

        if (contested) begin
            if (FIXED_PRIO == 0) winner_o = ~last_gnt_q;
            else                 winner_o = (starve_q == LIM) ? M_AUX : M_CPU;
        end else if (req_i[1]) begin
            winner_o = M_AUX;
        end

        if (fire_o) begin
            last_gnt_d = winner_o;
            // Any grant to the aux master ends its starvation run; uncontested CPU grants don't count.
            if (winner_o == M_AUX)                 starve_d = '0;
            else if (contested && starve_q != LIM) starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= M_AUX;
            starve_q   <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            starve_q   <= starve_d;
        end
    end
endmodule

// File: rtl/membus_arbiter.sv
// Two-master to one-slave single-beat arbiter for the device bus.
// Strobe one cycle after grant, ack 2 cycles (write) or 2+RD_LAT cycles (read) after grant; masters wait on ack.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    membus_arbiter_if.slave   m0,
    membus_arbiter_if.slave   m1,
    output logic              dev_rd,
    output logic              dev_wr,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wdata,
    input  logic [DATA_W-1:0] dev_rdata,
    output logic              busy,
    output logic              gnt_id
);
    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              winner, fire;
    logic              ack0, ack1;

    membus_pick #(
        .FIXED_PRIO (FIXED_PRIO),
        .STARVE_LIM (STARVE_LIM)
    ) u_pick (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_i    ({m1.req, m0.req}),
        .arb_en_i (state_q == IDLE),
        .winner_o (winner),
        .fire_o   (fire)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    gnt_d   = winner;
                    we_d    = winner ? m1.we    : m0.we;
                    addr_d  = winner ? m1.addr  : m0.addr;
                    wdata_d = winner ? m1.wdata : m0.wdata;
                    rdata_d = '0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (we_q) begin
                    state_d = ACK;
                end else if (RD_LAT == 0) begin
                    rdata_d = dev_rdata;
                    state_d = ACK;
                end else begin
                    cnt_d   = 3'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = dev_rdata;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= M_CPU;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Strobes and acks decode straight from state so an async reset kills them instantly.
    assign dev_rd    = (state_q == STROBE) & ~we_q;
    assign dev_wr    = (state_q == STROBE) &  we_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign gnt_id    = gnt_q;

    assign ack0     = (state_q == ACK) && (gnt_q == M_CPU);
    assign ack1     = (state_q == ACK) && (gnt_q == M_AUX);
    assign m0.ack   = ack0;
    assign m1.ack   = ack1;
    assign m0.rdata = ack0 ? rdata_q : '0;
    assign m1.rdata = ack1 ? rdata_q : '0;
endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: three instances cover RD_LAT 1/0/3 and both priority modes.
module tb_membus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_d_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a0 ();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d0 ();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d1 ();

    logic        dev_rd_a, dev_wr_a, busy_a, gnt_a;
    logic [31:0] dev_addr_a, dev_wdata_a, dev_rdata_a;
    logic        dev_rd_b, dev_wr_b, busy_b, gnt_b;
    logic [31:0] dev_addr_b, dev_wdata_b, dev_rdata_b;
    logic        dev_rd_d, dev_wr_d, busy_d, gnt_d;
    logic [31:0] dev_addr_d, dev_wdata_d, dev_rdata_d;

    membus_arbiter #(.RD_LAT(1), .FIXED_PRIO(0), .STARVE_LIM(4)) u_a (
        .clk(clk), .reset_n(rst_n), .m0(a0), .m1(a1),
        .dev_rd(dev_rd_a), .dev_wr(dev_wr_a), .dev_addr(dev_addr_a), .dev_wdata(dev_wdata_a),
        .dev_rdata(dev_rdata_a), .busy(busy_a), .gnt_id(gnt_a));

    membus_arbiter #(.RD_LAT(0), .FIXED_PRIO(1), .STARVE_LIM(4)) u_b (
        .clk(clk), .reset_n(rst_n), .m0(b0), .m1(b1),
        .dev_rd(dev_rd_b), .dev_wr(dev_wr_b), .dev_addr(dev_addr_b), .dev_wdata(dev_wdata_b),
        .dev_rdata(dev_rdata_b), .busy(busy_b), .gnt_id(gnt_b));

    membus_arbiter #(.RD_LAT(3), .FIXED_PRIO(0), .STARVE_LIM(4)) u_d (
        .clk(clk), .reset_n(rst_d_n), .m0(d0), .m1(d1),
        .dev_rd(dev_rd_d), .dev_wr(dev_wr_d), .dev_addr(dev_addr_d), .dev_wdata(dev_wdata_d),
        .dev_rdata(dev_rdata_d), .busy(busy_d), .gnt_id(gnt_d));

    task automatic test_reset();
        a0.req = 0; a0.we = 0; a0.addr = '0; a0.wdata = '0;
        a1.req = 0; a1.we = 0; a1.addr = '0; a1.wdata = '0;
        b0.req = 0; b0.we = 0; b0.addr = '0; b0.wdata = '0;
        b1.req = 0; b1.we = 0; b1.addr = '0; b1.wdata = '0;
        d0.req = 0; d0.we = 0; d0.addr = '0; d0.wdata = '0;
        d1.req = 0; d1.we = 0; d1.addr = '0; d1.wdata = '0;
        dev_rdata_a = '0; dev_rdata_b = '0; dev_rdata_d = '0;
        rst_n = 1'b0; rst_d_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_a, dev_rd_a, dev_wr_a, gnt_a, a0.ack, a1.ack} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_a: got %b required 000000", {busy_a, dev_rd_a, dev_wr_a, gnt_a, a0.ack, a1.ack});
        end
        n_checks++;
        if ({dev_addr_a, dev_wdata_a, a0.rdata} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data_a: got %h required 0", {dev_addr_a, dev_wdata_a, a0.rdata});
        end
        n_checks++;
        if ({busy_b, dev_rd_b, dev_wr_b, gnt_b, busy_d, dev_rd_d, dev_wr_d, gnt_d} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_bd: got %b required 00000000", {busy_b, dev_rd_b, dev_wr_b, gnt_b, busy_d, dev_rd_d, dev_wr_d, gnt_d});
        end
        rst_n = 1'b1; rst_d_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        a0.req = 1; a0.we = 1; a0.addr = 32'h4000_0010; a0.wdata = 32'h0000_00A5;
        @(negedge clk);
        n_checks++;
        if ({dev_wr_a, dev_rd_a, busy_a, gnt_a, a0.ack, dev_addr_a, dev_wdata_a} !== {5'b10100, 32'h4000_0010, 32'h0000_00A5}) begin
            n_fail++;
            $display("FAIL wr_strobe: got %h required %h", {dev_wr_a, dev_rd_a, busy_a, gnt_a, a0.ack, dev_addr_a, dev_wdata_a},
                     {5'b10100, 32'h4000_0010, 32'h0000_00A5});
        end
        @(negedge clk);
        n_checks++;
        if ({a0.ack, a1.ack, dev_wr_a, busy_a, a0.rdata} !== {4'b1001, 32'h0}) begin
            n_fail++;
            $display("FAIL wr_ack: got %h required %h", {a0.ack, a1.ack, dev_wr_a, busy_a, a0.rdata}, {4'b1001, 32'h0});
        end
        a0.req = 0;
        @(negedge clk);
        n_checks++;
        if ({a0.ack, a1.ack, busy_a, dev_wr_a} !== 4'b0) begin
            n_fail++;
            $display("FAIL wr_idle: got %b required 0000", {a0.ack, a1.ack, busy_a, dev_wr_a});
        end
    endtask

    task automatic test_read_lat1();
        a1.req = 1; a1.we = 0; a1.addr = 32'h4000_0020; dev_rdata_a = 32'h1111_1111;
        @(negedge clk);
        n_checks++;
        if ({dev_rd_a, dev_wr_a, gnt_a, dev_addr_a} !== {3'b101, 32'h4000_0020}) begin
            n_fail++;
            $display("FAIL rd1_strobe: got %h required %h", {dev_rd_a, dev_wr_a, gnt_a, dev_addr_a}, {3'b101, 32'h4000_0020});
        end
        @(negedge clk);
        n_checks++;
        if ({a1.ack, dev_rd_a, busy_a} !== 3'b001) begin
            n_fail++;
            $display("FAIL rd1_wait: got %b required 001", {a1.ack, dev_rd_a, busy_a});
        end
        dev_rdata_a = 32'hDEAD_BEEF;
        @(negedge clk);
        dev_rdata_a = 32'h2222_2222;
        n_checks++;
        if ({a1.ack, a0.ack, a1.rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL rd1_ack: got %h required %h", {a1.ack, a0.ack, a1.rdata}, {2'b10, 32'hDEAD_BEEF});
        end
        a1.req = 0;
        @(negedge clk);
        n_checks++;
        if ({a1.ack, busy_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd1_idle: got %b required 00", {a1.ack, busy_a});
        end
    endtask

    task automatic test_read_lat0();
        b1.req = 1; b1.we = 0; b1.addr = 32'h4000_0020; dev_rdata_b = 32'h1111_1111;
        @(negedge clk);
        n_checks++;
        if ({dev_rd_b, b1.ack, gnt_b, dev_addr_b} !== {3'b101, 32'h4000_0020}) begin
            n_fail++;
            $display("FAIL rd0_strobe: got %h required %h", {dev_rd_b, b1.ack, gnt_b, dev_addr_b}, {3'b101, 32'h4000_0020});
        end
        dev_rdata_b = 32'hCAFE_F00D;
        @(negedge clk);
        dev_rdata_b = 32'h3333_3333;
        n_checks++;
        if ({b1.ack, b0.ack, dev_rd_b, b1.rdata} !== {3'b100, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL rd0_ack: got %h required %h", {b1.ack, b0.ack, dev_rd_b, b1.rdata}, {3'b100, 32'hCAFE_F00D});
        end
        b1.req = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [5:0] seq = '0;
        int nack = 0, last_cyc = -1, overlap = 0;
        a0.req = 1; a0.we = 1; a0.addr = 32'h100; a0.wdata = 32'h10;
        a1.req = 1; a1.we = 1; a1.addr = 32'h200; a1.wdata = 32'h20;
        for (int cyc = 1; cyc <= 40 && nack < 6; cyc++) begin
            @(negedge clk);
            if (a0.ack && a1.ack) overlap++;
            if (a0.ack || a1.ack) begin
                seq[nack] = a1.ack;
                nack++;
                last_cyc = cyc;
                if (nack == 6) begin a0.req = 0; a1.req = 0; end
            end
        end
        a0.req = 0; a1.req = 0;
        n_checks++;
        if (nack != 6 || seq !== 6'b101010) begin
            n_fail++;
            $display("FAIL rr_order: got %0d acks order %b required 6 acks order 101010 (lsb first)", nack, seq);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL rr_overlap: got %0d coincident acks required 0", overlap);
        end
        n_checks++;
        if (last_cyc != 17) begin
            n_fail++;
            $display("FAIL rr_throughput: got sixth ack in cycle %0d required 17", last_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        logic [9:0] seq = '0;
        int nack = 0, overlap = 0;
        b0.req = 1; b0.we = 1; b0.addr = 32'h100; b0.wdata = 32'h10;
        b1.req = 1; b1.we = 1; b1.addr = 32'h200; b1.wdata = 32'h20;
        for (int cyc = 1; cyc <= 60 && nack < 10; cyc++) begin
            @(negedge clk);
            if (b0.ack && b1.ack) overlap++;
            if (b0.ack || b1.ack) begin
                seq[nack] = b1.ack;
                nack++;
                if (nack == 10) begin b0.req = 0; b1.req = 0; end
            end
        end
        b0.req = 0; b1.req = 0;
        n_checks++;
        if (nack != 10 || seq !== 10'b10_0001_0000) begin
            n_fail++;
            $display("FAIL fp_order: got %0d acks order %b required 10 acks order 1000010000 (lsb first)", nack, seq);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL fp_overlap: got %0d coincident acks required 0", overlap);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_early_drop();
        a0.req = 1; a0.we = 1; a0.addr = 32'h300; a0.wdata = 32'h33;
        @(negedge clk);
        n_checks++;
        if ({dev_wr_a, gnt_a, dev_addr_a} !== {2'b10, 32'h300}) begin
            n_fail++;
            $display("FAIL drop_strobe: got %h required %h", {dev_wr_a, gnt_a, dev_addr_a}, {2'b10, 32'h300});
        end
        a0.req = 0;
        a1.req = 1; a1.we = 1; a1.addr = 32'h400; a1.wdata = 32'h44;
        @(negedge clk);
        n_checks++;
        if ({a0.ack, a1.ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_ack: got %b required 10", {a0.ack, a1.ack});
        end
        @(negedge clk);
        n_checks++;
        if ({busy_a, dev_wr_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_idle: got %b required 00", {busy_a, dev_wr_a});
        end
        @(negedge clk);
        n_checks++;
        if ({dev_wr_a, gnt_a, dev_addr_a, dev_wdata_a} !== {2'b11, 32'h400, 32'h44}) begin
            n_fail++;
            $display("FAIL drop_m1_strobe: got %h required %h", {dev_wr_a, gnt_a, dev_addr_a, dev_wdata_a}, {2'b11, 32'h400, 32'h44});
        end
        @(negedge clk);
        n_checks++;
        if ({a1.ack, a0.ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_m1_ack: got %b required 10", {a1.ack, a0.ack});
        end
        a1.req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int stray = 0, ack_cyc = -1;
        logic ack_id = 1'b1;
        logic [31:0] ack_dat = '0;
        d0.req = 1; d0.we = 0; d0.addr = 32'h500; dev_rdata_d = 32'h5555_5555;
        @(negedge clk);
        n_checks++;
        if ({dev_rd_d, gnt_d, busy_d} !== 3'b101) begin
            n_fail++;
            $display("FAIL rst_pre_strobe: got %b required 101", {dev_rd_d, gnt_d, busy_d});
        end
        @(negedge clk);
        rst_d_n = 1'b0;
        d0.req = 0;
        #1;
        n_checks++;
        if ({busy_d, dev_rd_d, dev_wr_d, d0.ack, d1.ack, gnt_d, dev_addr_d} !== 38'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h required 0", {busy_d, dev_rd_d, dev_wr_d, d0.ack, d1.ack, gnt_d, dev_addr_d});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d0.ack || d1.ack || busy_d) stray++;
        end
        rst_d_n = 1'b1;
        @(negedge clk);
        if (d0.ack || d1.ack || busy_d) stray++;
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rst_no_ack: got %0d cycles with ack/busy required 0", stray);
        end
        d0.req = 1; d0.we = 0; d0.addr = 32'h600;
        d1.req = 1; d1.we = 0; d1.addr = 32'h700;
        dev_rdata_d = 32'h0000_0077;
        for (int cyc = 1; cyc <= 12 && ack_cyc < 0; cyc++) begin
            @(negedge clk);
            if (d0.ack || d1.ack) begin
                ack_cyc = cyc;
                ack_id  = d1.ack;
                ack_dat = d1.ack ? d1.rdata : d0.rdata;
                d0.req = 0; d1.req = 0;
            end
        end
        d0.req = 0; d1.req = 0;
        n_checks++;
        if (ack_cyc != 5 || ack_id !== 1'b0 || ack_dat !== 32'h77) begin
            n_fail++;
            $display("FAIL rst_first_grant: got ack cycle %0d master %b data %h required cycle 5 master 0 data 00000077",
                     ack_cyc, ack_id, ack_dat);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_lat1();
        test_read_lat0();
        test_round_robin();
        test_fixed_prio();
        test_early_drop();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
